sd_sector_responder: RTL

- Responder end of the core-side virtual SD sector protocol: `sd_lba`, `sd_rd`, `sd_wr`, `sd_ack`, `sd_buff_addr`, `sd_buff_dout`, `sd_buff_din`, `sd_buff_wr`.
- Services the backup-RAM load/save requests the SNES core issues, one 512-byte sector (256 x 16-bit words) per request.
- Backing store is a word-addressed memory behind a simple req/ready port. This enables simulation and standalone save storage without the HPS.

---
 rtl/sd_resp_pkg.sv | 17 +
 rtl/sd_sector_responder.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/sd_resp_pkg.sv
// Shared types and constants for the virtual SD sector responder.
package sd_resp_pkg;

    localparam int unsigned SECTOR_WORDS = 256;
    localparam logic [7:0]  LAST_IDX     = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        RD_FETCH,
        RD_PUSH,
        WR_ADDR,
        WR_CAP,
        WR_STORE,
        DONE
    } state_t;

endpackage

// File: rtl/sd_sector_responder.sv
// Responder end of the core-side virtual SD sector protocol, moving one
// 256-word sector per request between the core buffer and a word store.
module sd_sector_responder
    import sd_resp_pkg::*;
#(
    parameter int unsigned LBA_BITS = 8,
    parameter int unsigned MEM_AW   = 16
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [31:0]       sd_lba,
    input  logic              sd_rd,
    input  logic              sd_wr,
    output logic              sd_ack,
    output logic [7:0]        sd_buff_addr,
    output logic [15:0]       sd_buff_dout,
    input  logic [15:0]       sd_buff_din,
    output logic              sd_buff_wr,
    input  logic              present,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [15:0]       mem_din,
    input  logic [15:0]       mem_dout,
    input  logic              mem_ready
);

    localparam int unsigned IDX_W = $clog2(SECTOR_WORDS);

    state_t              state;
    logic [LBA_BITS-1:0] lba_q;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    idx_nx;
    logic                idx_last;
    logic                armed;
    logic                unused_lba_hi;

    assign idx_nx        = idx + IDX_W'(1);
    assign idx_last      = (idx == IDX_W'(LAST_IDX));
    assign unused_lba_hi = ^sd_lba[31:LBA_BITS];

    // Single FSM; every output is a register updated on state transitions.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            armed        <= 1'b1;
            lba_q        <= '0;
            idx          <= '0;
            sd_ack       <= 1'b0;
            sd_buff_addr <= 8'h00;
            sd_buff_dout <= 16'h0000;
            sd_buff_wr   <= 1'b0;
            mem_addr     <= '0;
            mem_rd       <= 1'b0;
            mem_wr       <= 1'b0;
            mem_din      <= 16'h0000;
        end else begin
            sd_buff_wr <= 1'b0;
            // Re-arm only once the request has been seen low, so a held level cannot retrigger.
            if (!sd_rd && !sd_wr) begin
                armed <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if ((sd_rd || sd_wr) && armed) begin
                        armed  <= 1'b0;
                        lba_q  <= sd_lba[LBA_BITS-1:0];
                        idx    <= '0;
                        sd_ack <= 1'b1;
                        if (sd_rd) begin
                            state    <= RD_FETCH;
                            mem_rd   <= present;
                            mem_addr <= MEM_AW'({sd_lba[LBA_BITS-1:0], 8'h00});
                        end else begin
                            state        <= WR_ADDR;
                            sd_buff_addr <= 8'h00;
                        end
                    end
                end

                RD_FETCH: begin
                    if (!mem_rd || mem_ready) begin
                        mem_rd       <= 1'b0;
                        sd_buff_wr   <= 1'b1;
                        sd_buff_addr <= 8'(idx);
                        sd_buff_dout <= mem_rd ? mem_dout : 16'h0000;
                        state        <= RD_PUSH;
                    end
                end

                RD_PUSH: begin
                    if (idx_last) begin
                        sd_ack <= 1'b0;
                        state  <= DONE;
                    end else begin
                        idx      <= idx_nx;
                        mem_rd   <= present;
                        mem_addr <= MEM_AW'({lba_q, 8'(idx_nx)});
                        state    <= RD_FETCH;
                    end
                end

                WR_ADDR: begin
                    state <= WR_CAP;
                end

                WR_CAP: begin
                    if (present) begin
                        mem_wr   <= 1'b1;
                        mem_din  <= sd_buff_din;
                        mem_addr <= MEM_AW'({lba_q, 8'(idx)});
                        state    <= WR_STORE;
                    end else if (idx_last) begin
                        sd_ack <= 1'b0;
                        state  <= DONE;
                    end else begin
                        idx          <= idx_nx;
                        sd_buff_addr <= 8'(idx_nx);
                        state        <= WR_ADDR;
                    end
                end

                WR_STORE: begin
                    if (mem_ready) begin
                        mem_wr <= 1'b0;
                        if (idx_last) begin
                            sd_ack <= 1'b0;
                            state  <= DONE;
                        end else begin
                            idx          <= idx_nx;
                            sd_buff_addr <= 8'(idx_nx);
                            state        <= WR_ADDR;
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
